// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx byte transmitter
// among NUM_REQ requesters. One byte is accepted per grant, issued as a
// registered single-cycle write strobe, and the transmitter's busy flag is
// tracked to completion before the next grant.
//
// Optional build macro: UART_ARB_TAG_EN
//   When defined, each grant sends a header byte {4'hA, id} ahead of the
//   payload byte. When undefined, only the payload byte is sent and no header
//   logic exists.
module uart_tx_arbiter #(
    parameter int  NUM_REQ     = 4,
    parameter int  ACK_TIMEOUT = 4,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [NUM_REQ*8-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic                 o_tx_wr,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy,
    output logic [ID_W-1:0]      o_grant_id,
    output logic                 o_active
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t                 state, state_nx;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        win;
    logic                   found;
    logic [2*NUM_REQ-1:0]   vld_dbl;
    logic [NUM_REQ-1:0]     vld_rot;
    logic [ID_W:0]          sum;
    logic [7:0]             byte_q;
    logic [7:0]             tx_byte;
    logic [CNT_W-1:0]       cnt;
    logic                   last_byte;
`ifdef UART_ARB_TAG_EN
    logic                   phase;  // 0: header in flight, 1: payload in flight
`endif

    // Rotate valids so the pointer position is bit 0, pick the lowest set bit,
    // then map the rotated index back to a requester id modulo NUM_REQ.
    always_comb begin
        vld_dbl = {i_req_valid, i_req_valid};
        vld_rot = vld_dbl[ptr +: NUM_REQ];
        found   = 1'b0;
        sum     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vld_rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (ID_W+1)'(i);
            end
        end
        if (sum >= (ID_W+1)'(NUM_REQ))
            sum = sum - (ID_W+1)'(NUM_REQ);
        win = sum[ID_W-1:0];
    end

    assign o_req_ready = (state == IDLE && found) ? (NUM_REQ'(1) << win) : '0;
    assign o_active    = (state != IDLE);

`ifdef UART_ARB_TAG_EN
    assign tx_byte   = phase ? byte_q : {4'hA, 4'(o_grant_id)};
    assign last_byte = phase;
`else
    assign tx_byte   = byte_q;
    assign last_byte = 1'b1;
`endif

    // Next-state logic: a strobe is only launched when the transmitter is idle,
    // and an unacknowledged strobe is abandoned after ACK_TIMEOUT cycles.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (found) state_nx = ISSUE;
            ISSUE:     if (!i_tx_busy) state_nx = WAIT_ACK;
            WAIT_ACK: begin
                if (i_tx_busy)
                    state_nx = WAIT_DONE;
                else if (cnt == CNT_W'(ACK_TIMEOUT - 1))
                    state_nx = IDLE;
            end
            WAIT_DONE: if (!i_tx_busy) state_nx = last_byte ? IDLE : ISSUE;
            default:   state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Datapath: capture on accept, strobe on issue, count while awaiting busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr        <= '0;
            byte_q     <= '0;
            o_grant_id <= '0;
            o_tx_wr    <= 1'b0;
            o_tx_data  <= '0;
            cnt        <= '0;
`ifdef UART_ARB_TAG_EN
            phase      <= 1'b0;
`endif
        end else begin
            o_tx_wr <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    byte_q     <= i_req_data[{win, 3'b000} +: 8];
                    o_grant_id <= win;
                    ptr        <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`ifdef UART_ARB_TAG_EN
                    phase      <= 1'b0;
`endif
                end
                ISSUE: if (!i_tx_busy) begin
                    o_tx_wr   <= 1'b1;
                    o_tx_data <= tx_byte;
                    cnt       <= '0;
                end
                WAIT_ACK: if (!i_tx_busy) cnt <= cnt + 1'b1;
`ifdef UART_ARB_TAG_EN
                WAIT_DONE: if (!i_tx_busy) phase <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level round-robin model and a small uart_tx
// busy model. Honours UART_ARB_TAG_EN when defined for the build.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 4;
`ifdef UART_ARB_TAG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b1;
    logic [NREQ-1:0]   i_req_valid;
    logic [NREQ*8-1:0] i_req_data;
    logic [NREQ-1:0]   o_req_ready;
    logic              o_tx_wr;
    logic [7:0]        o_tx_data;
    logic              i_tx_busy;
    logic [1:0]        o_grant_id;
    logic              o_active;

    int checks = 0, errors = 0;
    int ptr_m = 0;           // model round-robin pointer
    int exp_q[$];            // expected strobes: (id << 8) | byte
    int acc_k = -1;          // requester accepted this cycle
    int busy_cnt = 0, busy_len = 3;
    bit ack_en = 1'b1, force_busy = 1'b0;
    int nstrobe = 0;
    int n0;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .ACK_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .i_req_data(i_req_data),
        .o_req_ready(o_req_ready), .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data),
        .i_tx_busy(i_tx_busy), .o_grant_id(o_grant_id), .o_active(o_active)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Model: first valid requester at or after the pointer wins; on accept
    // the expected strobes for that grant are queued.
    task automatic check_ready();
        int w;
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (ptr_m + i) % NREQ;
            if (w < 0 && i_req_valid[j]) w = j;
        end
        if (o_req_ready != '0) begin
            chk("ready_onehot", o_req_ready, (w < 0) ? 0 : (1 << w));
            chk("ready_only_idle", o_active, 0);
            chk("ready_prev_done", exp_q.size(), 0);
            if (w >= 0 && o_req_ready[w]) begin
`ifdef UART_ARB_TAG_EN
                exp_q.push_back((w << 8) | 8'hA0 | w);
`endif
                exp_q.push_back((w << 8) | int'(i_req_data[8*w +: 8]));
                ptr_m = (w + 1) % NREQ;
                acc_k = w;
            end
        end
    endtask

    // One clock: check the pre-edge handshake, record strobes, advance the
    // uart_tx busy model, and retire the accepted request's valid.
    task automatic tick();
        logic       wr_s, bsy_s;
        logic [7:0] d_s;
        logic [1:0] id_s;
        int         e;
        #1;
        check_ready();
        wr_s = o_tx_wr; d_s = o_tx_data; id_s = o_grant_id; bsy_s = i_tx_busy;
        @(posedge i_clk);
        #1;
        if (wr_s) begin
            nstrobe++;
            chk("wr_while_busy", bsy_s, 0);
            chk("strobe_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("strobe_id_data", (int'(id_s) << 8) | int'(d_s), e);
            end
        end
        if (busy_cnt > 0) busy_cnt--;
        if (wr_s && ack_en) busy_cnt = busy_len;
        i_tx_busy = force_busy || (busy_cnt > 0);
        if (acc_k >= 0) begin
            i_req_valid[acc_k] = 1'b0;
            acc_k = -1;
        end
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (o_active && n < bound) begin
            tick();
            n++;
        end
        chk(tag, o_active, 0);
    endtask

    task automatic run_random(input int cycles, input int prob, input int drop);
        for (int c = 0; c < cycles; c++) begin
            busy_len = $urandom_range(1, 6);
            for (int k = 0; k < NREQ; k++) begin
                if (!i_req_valid[k] && $urandom_range(99) < prob) begin
                    i_req_valid[k] = 1'b1;
                    i_req_data[8*k +: 8] = 8'($urandom);
                end else if (i_req_valid[k] && $urandom_range(99) < drop) begin
                    i_req_valid[k] = 1'b0;
                end
            end
            tick();
        end
    endtask

    initial begin
        int n;
        i_req_valid = '0; i_req_data = '0; i_tx_busy = 1'b0;
        #1 i_rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_wr", o_tx_wr, 0);
        chk("rst_data", o_tx_data, 0);
        chk("rst_id", o_grant_id, 0);
        chk("rst_active", o_active, 0);
        chk("rst_ready", o_req_ready, 0);
        i_rst_n = 1'b1;
        tick();

        // Single request from requester 1.
        i_req_valid = 4'b0010; i_req_data[15:8] = 8'h55;
        #1 chk("single_ready", o_req_ready, 4'b0010);
        tick();
        chk("single_active", o_active, 1);
        chk("single_id", o_grant_id, 1);
        chk("single_no_wr_yet", o_tx_wr, 0);
        tick();
        chk("single_wr", o_tx_wr, 1);
`ifdef UART_ARB_TAG_EN
        chk("single_data", o_tx_data, 8'hA1);
`else
        chk("single_data", o_tx_data, 8'h55);
`endif
        wait_idle("single_done", 40);

        // Timeout: transmitter never acknowledges.
        ack_en = 1'b0;
        i_req_valid = 4'b0100; i_req_data[23:16] = 8'h77;
        tick();
        tick();
        chk("tmo_wr", o_tx_wr, 1);
        n0 = nstrobe;
        n = 0;
        while (o_active && n < 20) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, TMO);
        repeat (6) tick();
        chk("tmo_no_repeat", nstrobe, n0 + 1);
        chk("tmo_dropped_left", exp_q.size(), NB - 1);
        exp_q.delete();
        ack_en = 1'b1;
        i_req_valid = 4'b1000; i_req_data[31:24] = 8'h9A;
        #1 chk("tmo_next_ready", o_req_ready, 4'b1000);
        tick();
        wait_idle("tmo_next_done", 40);

        // Busy stall: transmitter busy on entry to ISSUE.
        force_busy = 1'b1; i_tx_busy = 1'b1;
        i_req_valid = 4'b0001; i_req_data[7:0] = 8'hC3;
        tick();
        n0 = nstrobe;
        repeat (20) tick();
        chk("stall_no_strobe", nstrobe, n0);
        chk("stall_active", o_active, 1);
        force_busy = 1'b0; i_tx_busy = (busy_cnt > 0);
        tick();
        chk("stall_wr", o_tx_wr, 1);
        wait_idle("stall_done", 60);
        chk("stall_strobes", nstrobe, n0 + NB);

        // Reset while waiting for the frame to finish.
        busy_len = 12;
        i_req_valid = 4'b0010; i_req_data[15:8] = 8'h5A;
        repeat (5) tick();
        chk("mid_active", o_active, 1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", o_tx_wr, 0);
        chk("mid_rst_data", o_tx_data, 0);
        chk("mid_rst_id", o_grant_id, 0);
        chk("mid_rst_active", o_active, 0);
        tick();
        i_rst_n = 1'b1;
        ptr_m = 0;
        exp_q.delete();
        busy_len = 3;
        i_req_valid = 4'b1010; i_req_data[15:8] = 8'h11; i_req_data[31:24] = 8'h33;
        #1 chk("post_rst_ready", o_req_ready, 4'b0010);
        tick();
        wait_idle("post_rst_1", 60);
        tick();
        wait_idle("post_rst_3", 60);

        // Contention, then random traffic with occasional withdrawn valids.
        run_random(80, 100, 0);
        run_random(600, 30, 5);
        i_req_valid = '0;
        wait_idle("drain", 100);
        chk("drain_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
